uart_bus_bridge: RTL and testbench
==================================

Name: uart_bus_bridge

Overview:
Serial-to-bus debug initiator. Consumes the received-byte stream of the UART receiver, decodes framed read/write commands, and drives the peripheral bus (read/write/address/write_data/read_data) as initiator. Returns an ack byte or read data through the UART transmitter. Sits between uart_tool_rx/uart_tool_tx and the bus decoder, giving host-side access to any peripheral without the CPU.

Parameters:
ADDR_BYTES, 4, number of address bytes per command, sent MSB first.
DATA_BYTES, 4, number of data bytes per write or read response, sent MSB first.
TIMEOUT_CYCLES, 2500000, maximum idle clk cycles between bytes of one frame. 100 ms at 25 MHz.
READ_LATENCY, 1, number of cycles read is held; read_data is sampled on the last of them.
CMD_WRITE, 8'h57, write command byte ('W').
CMD_READ, 8'h52, read command byte ('R').
ACK_BYTE, 8'h4B, write acknowledge ('K').

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
rx_data  in  8  received byte
tx_valid  out  1  tx_data valid; held until tx_ready
tx_ready  in  1  transmitter accepts byte (transfer on tx_valid && tx_ready)
tx_data  out  8  byte to transmit
read  out  1  bus read strobe
write  out  1  bus write strobe, one cycle
address  out  32  bus address
write_data  out  32  bus write data
read_data  in  32  bus read data, valid while read is high
rx_overrun  out  1  sticky: a byte arrived while the bridge was not accepting
frame_error  out  1  one-cycle pulse on a timeout or an unknown command

Behaviour:
- Async reset (resetn=0): state IDLE; every output 0; counters, address, write_data and shift registers cleared. Reset mid-frame or mid-response aborts the transaction with no bus strobe.
- States:
  - IDLE: wait for rx_valid. CMD_WRITE or CMD_READ latches op, goes to ADDR. Any other byte: frame_error pulse, stay in IDLE.
  - ADDR: shift each byte into address, {address[23:0], byte}. After ADDR_BYTES bytes, go to DATA if op=write, else BUS_RD.
  - DATA: shift bytes into write_data the same way. After DATA_BYTES bytes, go to BUS_WR.
  - BUS_WR: write=1 for exactly one cycle, then go to RESP with a single ACK_BYTE queued.
  - BUS_RD: read=1 for READ_LATENCY cycles. On the last cycle, latch read_data into the response register. Go to RESP with DATA_BYTES bytes queued.
  - RESP: present bytes MSB first (response[31:24] first). tx_valid stays high, tx_data stays stable until tx_ready. Advance on each transfer. After the last transfer, return to IDLE.
- Timing:
  - First bus strobe is asserted the cycle after the final frame byte's rx_valid.
  - tx_valid rises the cycle after the last strobe cycle.
- address and write_data hold their values after the transaction until overwritten by the next frame.
- Timeout:
  - A 32-bit counter clears on every accepted byte and increments in ADDR and DATA.
  - When it reaches TIMEOUT_CYCLES: frame_error pulse, return to IDLE, no bus access.
  - The counter is not active in IDLE, BUS_*, or RESP.
- Overrun: rx_valid in BUS_WR, BUS_RD or RESP drops the byte and sets rx_overrun. rx_overrun clears only on reset.
- rx_valid arriving in the same cycle the timeout fires: the timeout wins and the byte is discarded.
- Byte counter is 3 bits and resets on every state entry. There is no wrap within a frame.
- read and write are never high in the same cycle.

Decomposition:
- Shared package: state encoding (IDLE, ADDR, DATA, BUS_WR, BUS_RD, RESP), CMD_WRITE, CMD_READ, ACK_BYTE.
- One natural sub-module: bridge_timeout_counter (load/clear/enable, terminal-count pulse).
- Byte shifting stays in the top module.

Test Plan:
- Write: send 57 00 00 10 03 00 00 00 41 -> one write pulse with address=32'h00001003, write_data=32'h00000041; then tx byte 4B.
- Read: send 52 00 00 10 03 with read_data=32'hDEADBEEF during read -> read high 1 cycle at 32'h00001003; tx bytes DE AD BE EF in order.
- Backpressure: read response with tx_ready high only every 10th cycle -> tx_data stable while waiting; exactly 4 transfers; no byte repeated or skipped.
- Timeout: send 57 00 00, then TIMEOUT_CYCLES idle -> one frame_error pulse; no write; the next 52 frame completes normally.
- Unknown command and overrun:
  - Send 41 -> frame_error pulse.
  - Inject rx_valid during RESP -> rx_overrun=1 and the response is unaffected.
- Reset mid-RESP: deassert resetn after 2 of 4 read bytes -> all outputs 0 at once; no further tx_valid; the next frame works.

Source files
------------

// File: rtl/uart_bus_bridge_pkg.sv
// Shared types and command bytes for the UART-to-bus debug bridge.
package uart_bus_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_RESP
    } state_e;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] ACK_BYTE  = 8'h4B;

endpackage

// File: rtl/uart_bus_bridge_if.sv
// Byte stream in/out plus peripheral-bus initiator signals of the bridge.
interface uart_bus_bridge_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        rx_overrun;
    logic        frame_error;

    modport master (
        input  rx_valid, rx_data, tx_ready, read_data,
        output tx_valid, tx_data, read, write, address, write_data,
               rx_overrun, frame_error
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, read_data,
        input  tx_valid, tx_data, read, write, address, write_data,
               rx_overrun, frame_error
    );
endinterface

// File: rtl/uart_bus_bridge_timeout_counter.sv
// Inter-byte idle counter: clear wins over enable, tc flags the terminal count.
module bridge_timeout_counter #(
    parameter int unsigned LIMIT = 2500000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Independent of clear so a byte landing on the terminal cycle still loses.
    assign tc = enable && (count_q == 32'(LIMIT));

endmodule

// File: rtl/uart_bus_bridge.sv
// Decodes W/R frames from the UART byte stream, runs one bus access and
// returns an ack or the read word through the transmitter.
module uart_bus_bridge
    import uart_bus_bridge_pkg::*;
#(
    parameter int unsigned ADDR_BYTES     = 4,
    parameter int unsigned DATA_BYTES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter int unsigned READ_LATENCY   = 1
) (
    input  logic               clk,
    input  logic               resetn,
    uart_bus_bridge_if.master  bus
);

    state_e      state_q, state_d;
    logic        op_rd_q, op_rd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  lat_q, lat_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] resp_q, resp_d;
    logic        overrun_q, overrun_d;
    logic        ferr_q, ferr_d;

    logic        to_en, to_clr, to_tc;

    assign to_en  = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign to_clr = !to_en || bus.rx_valid;

    bridge_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .resetn (resetn),
        .clear  (to_clr),
        .enable (to_en),
        .tc     (to_tc)
    );

    always_comb begin
        state_d   = state_q;
        op_rd_d   = op_rd_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        resp_d    = resp_q;
        overrun_d = overrun_q;
        ferr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ) begin
                        op_rd_d = (bus.rx_data == CMD_READ);
                        cnt_d   = '0;
                        state_d = ST_ADDR;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (to_tc) begin
                    ferr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (bus.rx_valid) begin
                    addr_d = {addr_q[23:0], bus.rx_data};
                    if (cnt_q == 3'(ADDR_BYTES - 1)) begin
                        cnt_d   = '0;
                        lat_d   = '0;
                        state_d = op_rd_q ? ST_BUS_RD : ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_DATA: begin
                if (to_tc) begin
                    ferr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (bus.rx_valid) begin
                    wdata_d = {wdata_q[23:0], bus.rx_data};
                    if (cnt_q == 3'(DATA_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_BUS_WR;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_BUS_WR: begin
                resp_d  = {ACK_BYTE, 24'h0};
                cnt_d   = '0;
                state_d = ST_RESP;
            end
            ST_BUS_RD: begin
                // read_data is only trusted on the final cycle of the strobe.
                if (lat_q == 8'(READ_LATENCY - 1)) begin
                    resp_d  = bus.read_data;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (bus.tx_ready) begin
                    resp_d = {resp_q[23:0], 8'h00};
                    if (cnt_q == (op_rd_q ? 3'(DATA_BYTES - 1) : 3'd0)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.rx_valid && (state_q inside {ST_BUS_WR, ST_BUS_RD, ST_RESP})) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            op_rd_q   <= 1'b0;
            cnt_q     <= '0;
            lat_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            resp_q    <= '0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_rd_q   <= op_rd_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            resp_q    <= resp_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.tx_valid    = (state_q == ST_RESP);
    assign bus.tx_data     = resp_q[31:24];
    assign bus.read        = (state_q == ST_BUS_RD);
    assign bus.write       = (state_q == ST_BUS_WR);
    assign bus.address     = addr_q;
    assign bus.write_data  = wdata_q;
    assign bus.rx_overrun  = overrun_q;
    assign bus.frame_error = ferr_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed frames against a frame-level scoreboard of expected bus ops and tx bytes.
module tb_uart_bus_bridge;

    localparam int TO = 20;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    uart_bus_bridge_if bif();

    logic [31:0] rd_value;
    assign bif.read_data = bif.read ? rd_value : 32'h0;

    uart_bus_bridge #(
        .ADDR_BYTES(4), .DATA_BYTES(4), .TIMEOUT_CYCLES(TO), .READ_LATENCY(1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    int checks = 0;
    int errors = 0;
    op_t        exp_ops[$];
    logic [7:0] exp_tx[$];
    int exp_fe  = 0;
    int fe_seen = 0;
    logic [31:0] tx_word;
    int tx_n;
    bit bp_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame-level model: decode the whole frame and queue what the bus and tx side must show.
    task automatic model_frame(input logic [7:0] f[$]);
        op_t o;
        if (f[0] == 8'h57 && f.size() == 9) begin
            o.is_rd = 1'b0;
            o.addr  = {f[1], f[2], f[3], f[4]};
            o.data  = {f[5], f[6], f[7], f[8]};
            exp_ops.push_back(o);
            exp_tx.push_back(8'h4B);
        end else if (f[0] == 8'h52 && f.size() == 5) begin
            o.is_rd = 1'b1;
            o.addr  = {f[1], f[2], f[3], f[4]};
            o.data  = rd_value;
            exp_ops.push_back(o);
            for (int i = 3; i >= 0; i--) exp_tx.push_back(rd_value[i*8 +: 8]);
        end else if (f[0] != 8'h57 && f[0] != 8'h52) begin
            exp_fe++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bif.rx_valid = 1'b1;
        bif.rx_data  = b;
        @(posedge clk); #1;
        bif.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$]);
        model_frame(f);
        foreach (f[i]) send_byte(f[i]);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_ops.size() != 0) && n < maxc) begin
            @(posedge clk);
            n++;
        end
        step(2);
        chk("drain_tx", 32'(exp_tx.size()), 32'd0);
        chk("drain_ops", 32'(exp_ops.size()), 32'd0);
    endtask

    // tx_ready: always ready, or every 10th cycle under backpressure
    initial begin
        int c = 0;
        bif.tx_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            c++;
            bif.tx_ready = bp_mode ? (c % 10 == 0) : 1'b1;
        end
    end

    // Per-cycle compare against the scoreboard
    initial begin
        int         rd_run = 0;
        bit         prev_wr = 1'b0;
        bit         prev_hold = 1'b0;
        logic [7:0] prev_data = 8'h0;
        op_t        o;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                chk("reset_outputs", 32'(|{bif.tx_valid, bif.tx_data, bif.read, bif.write,
                    bif.address, bif.write_data, bif.rx_overrun, bif.frame_error}), 32'd0);
                rd_run = 0; prev_wr = 1'b0; prev_hold = 1'b0;
            end else begin
                chk("rd_wr_exclusive", 32'(bif.read && bif.write), 32'd0);
                if (bif.write) begin
                    if (prev_wr) chk("write_one_cycle", 32'(prev_wr), 32'd0);
                    else if (exp_ops.size() == 0 || exp_ops[0].is_rd) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write: got addr %h expected no write", bif.address);
                    end else begin
                        o = exp_ops.pop_front();
                        chk("wr_addr", bif.address, o.addr);
                        chk("wr_data", bif.write_data, o.data);
                    end
                end
                if (bif.read) begin
                    if (rd_run == 0) begin
                        if (exp_ops.size() == 0 || !exp_ops[0].is_rd) begin
                            checks++; errors++;
                            $display("FAIL unexpected_read: got addr %h expected no read", bif.address);
                        end else begin
                            o = exp_ops.pop_front();
                            chk("rd_addr", bif.address, o.addr);
                        end
                    end
                    rd_run++;
                end else if (rd_run > 0) begin
                    chk("read_len", 32'(rd_run), 32'd1);
                    rd_run = 0;
                end
                if (prev_hold) begin
                    chk("tx_hold_valid", 32'(bif.tx_valid), 32'd1);
                    chk("tx_hold_data", 32'(bif.tx_data), 32'(prev_data));
                end
                if (bif.tx_valid && bif.tx_ready) begin
                    if (exp_tx.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_tx: got %h expected no transfer", bif.tx_data);
                    end else begin
                        chk("tx_byte", 32'(bif.tx_data), 32'(exp_tx.pop_front()));
                    end
                    tx_word = {tx_word[23:0], bif.tx_data};
                    tx_n++;
                end
                if (bif.frame_error) fe_seen++;
                prev_wr   = bif.write;
                prev_hold = bif.tx_valid && !bif.tx_ready;
                prev_data = bif.tx_data;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] f[$];
        bif.rx_valid = 1'b0;
        bif.rx_data  = 8'h00;
        rd_value     = 32'h0;
        tx_word      = 32'h0;
        tx_n         = 0;
        step(3);
        chk("reset_tx_valid", 32'(bif.tx_valid), 32'd0);
        chk("reset_address", bif.address, 32'd0);
        resetn = 1'b1;
        step(2);

        // Write frame
        f = {8'h57, 8'h00, 8'h00, 8'h10, 8'h03, 8'h00, 8'h00, 8'h00, 8'h41};
        send_frame(f);
        chk("wr_strobe_now", 32'(bif.write), 32'd1);
        chk("wr_addr_lit", bif.address, 32'h00001003);
        chk("wr_data_lit", bif.write_data, 32'h00000041);
        chk("wr_no_tx_yet", 32'(bif.tx_valid), 32'd0);
        step(1);
        chk("wr_strobe_gone", 32'(bif.write), 32'd0);
        chk("ack_valid", 32'(bif.tx_valid), 32'd1);
        chk("ack_byte_lit", 32'(bif.tx_data), 32'h4B);
        wait_drain(50);
        chk("addr_held", bif.address, 32'h00001003);

        // Read frame
        rd_value = 32'hDEADBEEF;
        tx_n = 0;
        f = {8'h52, 8'h00, 8'h00, 8'h10, 8'h03};
        send_frame(f);
        chk("rd_strobe_now", 32'(bif.read), 32'd1);
        chk("rd_addr_lit", bif.address, 32'h00001003);
        step(1);
        chk("rd_strobe_gone", 32'(bif.read), 32'd0);
        chk("rd_first_byte", 32'(bif.tx_data), 32'hDE);
        wait_drain(50);
        chk("rd_word_lit", tx_word, 32'hDEADBEEF);
        chk("rd_count", 32'(tx_n), 32'd4);

        // Backpressured read with an overrun byte injected during RESP
        rd_value = 32'h12345678;
        tx_n = 0;
        bp_mode = 1'b1;
        f = {8'h52, 8'h00, 8'h00, 8'h20, 8'h00};
        send_frame(f);
        step(3);
        chk("overrun_before", 32'(bif.rx_overrun), 32'd0);
        send_byte(8'hAA);
        chk("overrun_set", 32'(bif.rx_overrun), 32'd1);
        wait_drain(300);
        bp_mode = 1'b0;
        chk("bp_word_lit", tx_word, 32'h12345678);
        chk("bp_count", 32'(tx_n), 32'd4);
        chk("overrun_sticky", 32'(bif.rx_overrun), 32'd1);

        // Unknown command
        f = {8'h41};
        send_frame(f);
        chk("unknown_fe", 32'(bif.frame_error), 32'd1);
        step(1);
        chk("unknown_fe_pulse", 32'(bif.frame_error), 32'd0);

        // Timeout; a byte in the firing cycle is dropped, not taken as a command
        f = {8'h57, 8'h00, 8'h00};
        send_frame(f);
        exp_fe++;
        step(TO);
        chk("fe_before_timeout", 32'(bif.frame_error), 32'd0);
        send_byte(8'h57);
        chk("timeout_fe", 32'(bif.frame_error), 32'd1);
        step(1);
        rd_value = 32'hCAFEF00D;
        tx_n = 0;
        f = {8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
        send_frame(f);
        wait_drain(50);
        chk("post_to_word", tx_word, 32'hCAFEF00D);
        chk("fe_count", 32'(fe_seen), 32'(exp_fe));

        // Reset after two of four response bytes
        rd_value = 32'hA5A55A5A;
        tx_n = 0;
        f = {8'h52, 8'h00, 8'h00, 8'h00, 8'h0C};
        send_frame(f);
        step(3);
        resetn = 1'b0;
        exp_tx.delete();
        #1;
        chk("rst_tx_valid", 32'(bif.tx_valid), 32'd0);
        chk("rst_overrun", 32'(bif.rx_overrun), 32'd0);
        chk("rst_address", bif.address, 32'd0);
        chk("rst_partial", 32'(tx_n), 32'd2);
        step(2);
        resetn = 1'b1;
        step(5);
        f = {8'h57, 8'h00, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(f);
        wait_drain(50);
        chk("post_rst_wdata", bif.write_data, 32'h11223344);
        chk("fe_final", 32'(fe_seen), 32'(exp_fe));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
